// File: rtl/Led7thanh.sv
// Single-digit BCD to 7-segment decoder, active-high segments {g,f,e,d,c,b,a}.
// Codes above 9 blank the digit.
module Led7thanh (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        unique case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/bcd_range_counter.sv
// Multi-digit BCD up/down counter for calendar/clock fields with a run-time
// upper limit, preset with validation, chainable carry/borrow and 7-seg outputs.
module bcd_range_counter #(
    parameter int unsigned NDIG    = 2,
    parameter int unsigned MIN_VAL = 1,
    parameter int unsigned MAX_VAL = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              dir,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic              lim_en,
    input  logic [4*NDIG-1:0] lim_val,
    output logic [4*NDIG-1:0] bcd,
    output logic [7*NDIG-1:0] seg,
    output logic              cy,
    output logic              bw,
    output logic              at_max,
    output logic              at_min,
    output logic              load_err
);

    localparam int unsigned W  = 4 * NDIG;
    // Wide enough for 9999, the largest 4-digit value.
    localparam int unsigned VW = 14;

    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  t;
        r = '0;
        t = v;
        for (int unsigned k = 0; k < NDIG; k++) begin
            r[4*k+:4] = 4'(t % 10);
            t         = t / 10;
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] to_bin(input logic [W-1:0] v);
        logic [VW-1:0] r;
        r = '0;
        for (int k = int'(NDIG) - 1; k >= 0; k--) begin
            r = r * VW'(10) + VW'(v[4*k+:4]);
        end
        return r;
    endfunction

    function automatic logic is_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (v[4*k+:4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    localparam logic [W-1:0]  MIN_BCD = to_bcd(MIN_VAL);
    localparam logic [W-1:0]  MAX_BCD = to_bcd(MAX_VAL);
    localparam logic [VW-1:0] MIN_BIN = VW'(MIN_VAL);
    localparam logic [VW-1:0] MAX_BIN = VW'(MAX_VAL);

    logic [W-1:0]  bcd_q, bcd_d;
    logic          load_err_q, load_err_d;

    logic [VW-1:0] cur_bin;
    logic [VW-1:0] lim_bin;
    logic [VW-1:0] load_bin;
    logic [VW-1:0] eff_max_bin;
    logic [W-1:0]  eff_max_bcd;
    logic          lim_ok;
    logic          load_ok;
    logic          ge_max;
    logic          gt_max;
    logic          le_min;

    logic [W-1:0]  inc_val;
    logic [W-1:0]  dec_val;
    logic          inc_carry;
    logic          dec_borrow;

    assign cur_bin  = to_bin(bcd_q);
    assign lim_bin  = to_bin(lim_val);
    assign load_bin = to_bin(load_val);

    // An out-of-range or malformed limit falls back to the static maximum.
    assign lim_ok      = lim_en && is_bcd(lim_val) && (lim_bin >= MIN_BIN) && (lim_bin <= MAX_BIN);
    assign eff_max_bcd = lim_ok ? lim_val : MAX_BCD;
    assign eff_max_bin = lim_ok ? lim_bin : MAX_BIN;

    assign load_ok = is_bcd(load_val) && (load_bin >= MIN_BIN) && (load_bin <= eff_max_bin);

    assign ge_max = (cur_bin >= eff_max_bin);
    assign gt_max = (cur_bin > eff_max_bin);
    assign le_min = (cur_bin <= MIN_BIN);

    // Ripple BCD increment: a 9 rolls to 0 and passes the carry upward.
    always_comb begin
        inc_val   = bcd_q;
        inc_carry = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (inc_carry) begin
                if (bcd_q[4*k+:4] >= 4'd9) begin
                    inc_val[4*k+:4] = 4'd0;
                end else begin
                    inc_val[4*k+:4] = bcd_q[4*k+:4] + 4'd1;
                    inc_carry       = 1'b0;
                end
            end
        end
    end

    // Ripple BCD decrement: a 0 rolls to 9 and borrows from the next digit.
    always_comb begin
        dec_val    = bcd_q;
        dec_borrow = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (dec_borrow) begin
                if (bcd_q[4*k+:4] == 4'd0) begin
                    dec_val[4*k+:4] = 4'd9;
                end else begin
                    dec_val[4*k+:4] = bcd_q[4*k+:4] - 4'd1;
                    dec_borrow      = 1'b0;
                end
            end
        end
    end

    always_comb begin
        bcd_d      = bcd_q;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                bcd_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (dir) begin
                bcd_d = ge_max ? MIN_BCD : inc_val;
            end else if (le_min || gt_max) begin
                // Also pulls a value stranded above a lowered limit back onto it.
                bcd_d = eff_max_bcd;
            end else begin
                bcd_d = dec_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_q      <= MIN_BCD;
            load_err_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd      = bcd_q;
    assign load_err = load_err_q;
    assign cy       = en && dir && !load && ge_max;
    assign bw       = en && !dir && !load && le_min;
    assign at_max   = (cur_bin == eff_max_bin);
    assign at_min   = (cur_bin == MIN_BIN);

    for (genvar k = 0; k < NDIG; k++) begin : g_seg
        Led7thanh u_led (
            .bcd(bcd_q[4*k+:4]),
            .seg(seg[7*k+:7])
        );
    end

endmodule

// File: tb/tb_bcd_range_counter.sv
// Bench for bcd_range_counter: a month-style (1..12) and a day-style (1..31)
// instance checked against an integer model, directed cases then random traffic.
module tb_bcd_range_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        a_en, a_dir, a_load, a_lim_en;
    logic [7:0]  a_load_val, a_lim_val, a_bcd;
    logic [13:0] a_seg;
    logic        a_cy, a_bw, a_at_max, a_at_min, a_load_err;

    logic        b_en, b_dir, b_load, b_lim_en;
    logic [7:0]  b_load_val, b_lim_val, b_bcd;
    logic [13:0] b_seg;
    logic        b_cy, b_bw, b_at_max, b_at_min, b_load_err;

    bcd_range_counter #(.NDIG(2), .MIN_VAL(1), .MAX_VAL(12)) u_mon (
        .clk(clk), .reset_n(reset_n), .en(a_en), .dir(a_dir), .load(a_load),
        .load_val(a_load_val), .lim_en(a_lim_en), .lim_val(a_lim_val), .bcd(a_bcd),
        .seg(a_seg), .cy(a_cy), .bw(a_bw), .at_max(a_at_max), .at_min(a_at_min),
        .load_err(a_load_err)
    );

    bcd_range_counter #(.NDIG(2), .MIN_VAL(1), .MAX_VAL(31)) u_day (
        .clk(clk), .reset_n(reset_n), .en(b_en), .dir(b_dir), .load(b_load),
        .load_val(b_load_val), .lim_en(b_lim_en), .lim_val(b_lim_val), .bcd(b_bcd),
        .seg(b_seg), .cy(b_cy), .bw(b_bw), .at_max(b_at_max), .at_min(b_at_min),
        .load_err(b_load_err)
    );

    int total = 0;
    int bad   = 0;
    int va, ea, vb, eb;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal value of a 2-digit BCD word, or -1 if any digit is above 9.
    function automatic int dec_of(input logic [7:0] v);
        int hi, lo;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        if (hi > 9 || lo > 9) return -1;
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] bcd8(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [13:0] seg_of(input int v);
        return {seg_tab[(v / 10) % 10], seg_tab[v % 10]};
    endfunction

    function automatic int effmax(input logic le, input logic [7:0] lv, input int mn,
                                  input int mx);
        int d;
        d = dec_of(lv);
        if (le && d >= 0 && d >= mn && d <= mx) return d;
        return mx;
    endfunction

    task automatic next_val(input logic en, input logic dir, input logic load,
                            input logic [7:0] lv, input logic le, input logic [7:0] limv,
                            input int mn, input int mx, inout int v, inout int e);
        int em, d;
        em = effmax(le, limv, mn, mx);
        e  = 0;
        if (load) begin
            d = dec_of(lv);
            if (d >= 0 && d >= mn && d <= em) v = d;
            else e = 1;
        end else if (en) begin
            if (dir) v = (v >= em) ? mn : v + 1;
            else if (v <= mn || v > em) v = em;
            else v = v - 1;
        end
    endtask

    task automatic check_comb();
        int ema, emb;
        ema = effmax(a_lim_en, a_lim_val, 1, 12);
        emb = effmax(b_lim_en, b_lim_val, 1, 31);
        chk("a_cy", a_cy, a_en && a_dir && !a_load && va >= ema);
        chk("a_bw", a_bw, a_en && !a_dir && !a_load && va <= 1);
        chk("a_at_max", a_at_max, va == ema);
        chk("a_at_min", a_at_min, va == 1);
        chk("b_cy", b_cy, b_en && b_dir && !b_load && vb >= emb);
        chk("b_bw", b_bw, b_en && !b_dir && !b_load && vb <= 1);
        chk("b_at_max", b_at_max, vb == emb);
        chk("b_at_min", b_at_min, vb == 1);
    endtask

    task automatic check_state();
        chk("a_bcd", a_bcd, bcd8(va));
        chk("a_load_err", a_load_err, ea);
        chk("a_seg", a_seg, seg_of(va));
        chk("b_bcd", b_bcd, bcd8(vb));
        chk("b_load_err", b_load_err, eb);
        chk("b_seg", b_seg, seg_of(vb));
    endtask

    task automatic tick();
        #1;
        check_comb();
        next_val(a_en, a_dir, a_load, a_load_val, a_lim_en, a_lim_val, 1, 12, va, ea);
        next_val(b_en, b_dir, b_load, b_load_val, b_lim_en, b_lim_val, 1, 31, vb, eb);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic load_a(input logic [7:0] v);
        a_load = 1'b1;
        a_load_val = v;
        tick();
        a_load = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] v);
        b_load = 1'b1;
        b_load_val = v;
        tick();
        b_load = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        {a_en, a_dir, a_load, a_lim_en} = '0;
        {b_en, b_dir, b_load, b_lim_en} = '0;
        a_load_val = '0; a_lim_val = '0;
        b_load_val = '0; b_lim_val = '0;
        va = 1; ea = 0; vb = 1; eb = 0;
        #12;
        chk("rst_a_bcd", a_bcd, 8'h01);
        chk("rst_a_seg", a_seg, {7'h3F, 7'h06});
        chk("rst_a_err", a_load_err, 0);
        chk("rst_b_bcd", b_bcd, 8'h01);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_state();

        // Month: up wrap with carry, digit carry
        load_a(8'h11);
        a_en = 1'b1; a_dir = 1'b1;
        #1 chk("cy_at_11", a_cy, 0);
        tick();
        chk("up_12", a_bcd, 8'h12);
        #1 chk("cy_at_12", a_cy, 1);
        tick();
        chk("wrap_01", a_bcd, 8'h01);
        a_en = 1'b0;
        load_a(8'h09);
        a_en = 1'b1;
        tick();
        chk("carry_10", a_bcd, 8'h10);
        a_en = 1'b0;

        // Month: down wrap with borrow, digit borrow
        load_a(8'h01);
        a_en = 1'b1; a_dir = 1'b0;
        #1 chk("bw_at_01", a_bw, 1);
        tick();
        chk("dwrap_12", a_bcd, 8'h12);
        a_en = 1'b0;
        load_a(8'h10);
        a_en = 1'b1;
        tick();
        chk("borrow_09", a_bcd, 8'h09);
        a_en = 1'b0;

        // Day with run-time limit
        b_lim_en = 1'b1; b_lim_val = 8'h28;
        load_b(8'h28);
        b_en = 1'b1; b_dir = 1'b1;
        #1 chk("cy_day28", b_cy, 1);
        tick();
        chk("day28_wrap", b_bcd, 8'h01);
        b_en = 1'b0;
        b_lim_val = 8'h31;
        load_b(8'h31);
        b_lim_val = 8'h30;
        tick();
        chk("day31_hold", b_bcd, 8'h31);
        chk("day31_not_max", b_at_max, 0);
        b_en = 1'b1; b_dir = 1'b1;
        #1 chk("cy_day31", b_cy, 1);
        tick();
        chk("day31_up_wrap", b_bcd, 8'h01);
        b_en = 1'b0;
        b_lim_val = 8'h31;
        load_b(8'h31);
        b_lim_val = 8'h30;
        b_en = 1'b1; b_dir = 1'b0;
        #1 chk("bw_day31", b_bw, 0);
        tick();
        chk("day31_down", b_bcd, 8'h30);
        b_en = 1'b0;

        // Preset validation
        load_a(8'h12);
        load_a(8'h13);
        chk("rej13_bcd", a_bcd, 8'h12);
        chk("rej13_err", a_load_err, 1);
        tick();
        chk("rej13_err_clr", a_load_err, 0);
        load_a(8'h0A);
        chk("rej0a_bcd", a_bcd, 8'h12);
        chk("rej0a_err", a_load_err, 1);
        a_en = 1'b1; a_dir = 1'b1; a_load = 1'b1; a_load_val = 8'h07;
        #1 chk("load_cy", a_cy, 0);
        tick();
        chk("load_07", a_bcd, 8'h07);
        a_load = 1'b0;

        // Async reset between edges while counting
        b_en = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        va = 1; ea = 0; vb = 1; eb = 0;
        chk("arst_a", a_bcd, 8'h01);
        chk("arst_b", b_bcd, 8'h01);
        a_en = 1'b0; b_en = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_state();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            a_en       = ($urandom_range(0, 9) < 7);
            a_dir      = 1'($urandom_range(0, 1));
            a_load     = ($urandom_range(0, 9) == 0);
            a_load_val = $urandom_range(0, 1) ? bcd8(int'($urandom_range(0, 15))) : 8'($urandom);
            a_lim_en   = 1'($urandom_range(0, 1));
            a_lim_val  = $urandom_range(0, 1) ? bcd8(int'($urandom_range(0, 15))) : 8'($urandom);
            b_en       = ($urandom_range(0, 9) < 7);
            b_dir      = 1'($urandom_range(0, 1));
            b_load     = ($urandom_range(0, 9) == 0);
            b_load_val = $urandom_range(0, 1) ? bcd8(int'($urandom_range(0, 35))) : 8'($urandom);
            b_lim_en   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       b_lim_val = bcd8(int'($urandom_range(28, 31)));
                1:       b_lim_val = bcd8(int'($urandom_range(0, 40)));
                default: b_lim_val = 8'($urandom);
            endcase
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
